// File: rtl/demux4_pkg.sv
// demux4_pkg: shared constants and types for the demux4_stream slice.
//   CH_NUM     - number of output channels
//   SEL_W      - width of a channel index
//   ch_idx_t   - channel index type
//   RST_ACTIVE - level of the reset input that asserts reset
package demux4_pkg;
   localparam int   CH_NUM     = 4;
   localparam int   SEL_W      = 2;
   localparam logic RST_ACTIVE = 1'b0;

   typedef logic [SEL_W-1:0] ch_idx_t;
endpackage

// File: rtl/demux4_stream_if.sv
// demux4_stream_if: stream bus of the 1-to-4 demultiplexer.
//   Producer side : in_valid, in_ready, in_data, sel
//   Consumer side : out_valid[3:0], out_ready[3:0], out_data0..out_data3
//   Status        : xfer_cnt (accepted-word count, wraps)
//   Modports      : slave  - the demultiplexer
//                   master - producer/consumers driving it
interface demux4_stream_if #(parameter int WIDTH = 1);
   import demux4_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [WIDTH-1:0]    in_data;
   ch_idx_t             sel;
   logic [CH_NUM-1:0]   out_valid;
   logic [CH_NUM-1:0]   out_ready;
   logic [WIDTH-1:0]    out_data0;
   logic [WIDTH-1:0]    out_data1;
   logic [WIDTH-1:0]    out_data2;
   logic [WIDTH-1:0]    out_data3;
   logic [31:0]         xfer_cnt;

   modport slave (
      input  in_valid, in_data, sel, out_ready,
      output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, xfer_cnt
   );

   modport master (
      output in_valid, in_data, sel, out_ready,
      input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, xfer_cnt
   );
endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-deep holding register for a single output channel.
//   clk, reset    - clock, async active-low reset
//   load          - write load_data this cycle (sets valid)
//   load_data     - word to hold
//   drain         - consumer takes the held word this cycle
//   valid, data   - holding register state
// A load wins over a drain in the same cycle, so a full slot being read
// can be refilled without a bubble. Data is not cleared on drain.
module demux_slot
   import demux4_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             drain,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   always_ff @(posedge clk or negedge reset) begin
      if (reset == RST_ACTIVE) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 stream demultiplexer.
//   clk, reset - clock, async active-low reset
//   bus        - demux4_stream_if.slave (input stream, four output
//                channels, xfer_cnt)
// Build option DEMUX4_ROUND_ROBIN_EN: sel is ignored and words are dealt
// to channels 0,1,2,3,0,... by an internal pointer that advances on every
// accept. Without it the target channel is sel.
module demux4_stream
   import demux4_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic            clk,
   input  logic            reset,
   demux4_stream_if.slave  bus
);

   ch_idx_t                       tgt;
   logic                          in_rdy;
   logic                          acc;
   logic [CH_NUM-1:0]             load;
   logic [CH_NUM-1:0]             drain;
   logic [CH_NUM-1:0]             valid;
   logic [CH_NUM-1:0][WIDTH-1:0]  data;
   logic [31:0]                   cnt_q;

`ifdef DEMUX4_ROUND_ROBIN_EN
   ch_idx_t ptr;

   // Pointer waits on a full channel rather than skipping it, so the
   // distribution order is strict.
   always_ff @(posedge clk or negedge reset) begin
      if (reset == RST_ACTIVE) ptr <= '0;
      else if (acc)            ptr <= ptr + 1'b1;
   end

   assign tgt = ptr;
`else
   assign tgt = bus.sel;
`endif

   // Ready depends only on the target slot, never on in_valid.
   assign in_rdy = ~valid[tgt] | bus.out_ready[tgt];
   assign acc    = bus.in_valid & in_rdy;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      assign load[g]  = acc & (tgt == ch_idx_t'(g));
      assign drain[g] = valid[g] & bus.out_ready[g];

      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk       (clk),
         .reset     (reset),
         .load      (load[g]),
         .load_data (bus.in_data),
         .drain     (drain[g]),
         .valid     (valid[g]),
         .data      (data[g])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (reset == RST_ACTIVE) cnt_q <= '0;
      else if (acc)            cnt_q <= cnt_q + 32'd1;
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = valid;
   assign bus.out_data0 = data[0];
   assign bus.out_data1 = data[1];
   assign bus.out_data2 = data[2];
   assign bus.out_data3 = data[3];
   assign bus.xfer_cnt  = cnt_q;

endmodule
